jk_toggle_monitor: RTL and testbench

//  Downstream observer for the JK flip-flop FSM output y. Samples y every enabled cycle.

---
 rtl/jk_toggle_monitor_pkg.sv | 26 ++
 rtl/jk_mon_run_timer.sv | 46 ++++
 rtl/jk_toggle_monitor.sv | 141 ++++++++++++++
 tb/tb_jk_toggle_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_toggle_monitor_pkg.sv
// ---------------------------------------------------------------------------
// jk_toggle_monitor_pkg
//   Shared definitions for the JK toggle monitor: mon_state encodings and the
//   mon_state width. Benches can import this to decode mon_state.
//   Contents:
//     MON_STATE_W   width of the mon_state output (2)
//     mon_state_e   S_INIT=0, S_LOW=1, S_HIGH=2, S_STUCK=3
//     level_state() maps a sampled y level to its tracking state
// ---------------------------------------------------------------------------
package jk_toggle_monitor_pkg;

    localparam int unsigned MON_STATE_W = 2;

    typedef enum logic [MON_STATE_W-1:0] {
        S_INIT  = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_STUCK = 2'd3
    } mon_state_e;

    // Tracking state for a sampled level.
    function automatic mon_state_e level_state(input logic level);
        return level ? S_HIGH : S_LOW;
    endfunction

endpackage

// File: rtl/jk_mon_run_timer.sv
// ---------------------------------------------------------------------------
// jk_mon_run_timer
//   Saturating run-length counter. It counts equal samples since the last
//   toggle, baseline or clear. It also flags the sample that completes a run
//   of STUCK_LEN equal samples.
//   Parameters:
//     STUCK_LEN  equal samples that make up a stuck run (legal range >= 2)
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous reset, active-low
//     inc   in   an enabled sample matched the previous level
//     clr   in   restart the run (toggle or external clear); wins over inc
//     hit   out  this edge's inc completes the stuck run (combinational)
// ---------------------------------------------------------------------------
module jk_mon_run_timer #(
    parameter int unsigned STUCK_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    // The run counter holds 0 .. STUCK_LEN-1.
    localparam int unsigned RUN_W = (STUCK_LEN > 2) ? $clog2(STUCK_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LEN - 1);
    // The baseline or toggle sample is the first of the run, so the
    // STUCK_LEN-th equal sample arrives while run_len is STUCK_LEN-2.
    localparam logic [RUN_W-1:0] HIT_VAL = RUN_W'(STUCK_LEN - 2);

    logic [RUN_W-1:0] run_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_len <= '0;
        end else if (clr) begin
            run_len <= '0;
        end else if (inc && (run_len != RUN_MAX)) begin
            run_len <= run_len + 1'b1;
        end
    end

    assign hit = inc && !clr && (run_len == HIT_VAL);

endmodule

// File: rtl/jk_toggle_monitor.sv
// ---------------------------------------------------------------------------
// jk_toggle_monitor
//   Observes the y output of the JK flip-flop FSM once per enabled cycle. It
//   emits one-cycle rise/fall pulses and keeps a saturating toggle count. It
//   flags y as stuck when y holds one level for STUCK_LEN enabled samples.
//   All outputs are registered.
//   Optional build macro:
//     JK_MON_HIST_EN  adds hist[7:0], the last 8 enabled y samples (LSB newest)
//   Parameters:
//     CNT_W      toggle_cnt width; saturates at 2**CNT_W-1
//     STUCK_LEN  equal samples before stuck asserts (>= 2)
//   Ports:
//     clk         in   rising-edge clock
//     rst         in   synchronous reset, active-low
//     en          in   sample enable; 0 freezes all state
//     clear       in   synchronous clear of count, sat flag and run length
//     y_in        in   y output of the JK FSM
//     rise_pulse  out  1-cycle pulse on a sampled 0->1
//     fall_pulse  out  1-cycle pulse on a sampled 1->0
//     toggle_cnt  out  saturating number of sampled toggles
//     cnt_sat     out  sticky; set when toggle_cnt reaches all-ones
//     stuck       out  high while in S_STUCK
//     mon_state   out  current state encoding
//     hist        out  sample history (only with JK_MON_HIST_EN)
// ---------------------------------------------------------------------------
module jk_toggle_monitor
    import jk_toggle_monitor_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned STUCK_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clear,
    input  logic                   y_in,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [CNT_W-1:0]       toggle_cnt,
    output logic                   cnt_sat,
    output logic                   stuck,
    output logic [MON_STATE_W-1:0] mon_state
`ifdef JK_MON_HIST_EN
    ,
    output logic [7:0]             hist
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mon_state_e state;
    logic       y_q;
    logic       toggle_now;
    logic       hold_now;
    logic       run_hit;

    // The baseline sample in S_INIT is neither a toggle nor a hold.
    assign toggle_now = en && (state != S_INIT) && (y_in != y_q);
    assign hold_now   = en && (state != S_INIT) && (y_in == y_q);

    jk_mon_run_timer #(
        .STUCK_LEN (STUCK_LEN)
    ) u_run_timer (
        .clk (clk),
        .rst (rst),
        .inc (hold_now),
        .clr (clear || toggle_now),
        .hit (run_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_INIT;
            y_q        <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            toggle_cnt <= '0;
            cnt_sat    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            // Pulses last one cycle and are never produced while en is low.
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            if (en) begin
                unique case (state)
                    S_INIT: begin
                        y_q   <= y_in;
                        state <= level_state(y_in);
                    end
                    S_LOW, S_HIGH, S_STUCK: begin
                        if (toggle_now) begin
                            y_q        <= y_in;
                            rise_pulse <= y_in;
                            fall_pulse <= ~y_in;
                            state      <= level_state(y_in);
                            stuck      <= 1'b0;
                            // A concurrent clear wins over the increment.
                            if (!clear && (toggle_cnt != CNT_MAX)) begin
                                toggle_cnt <= toggle_cnt + 1'b1;
                                if (toggle_cnt == CNT_MAX - 1'b1) begin
                                    cnt_sat <= 1'b1;
                                end
                            end
                        end else if (run_hit) begin
                            state <= S_STUCK;
                            stuck <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_INIT;
                    end
                endcase
            end

            if (clear) begin
                toggle_cnt <= '0;
                cnt_sat    <= 1'b0;
                // A toggle in this cycle already picked the new state.
                if ((state == S_STUCK) && !toggle_now) begin
                    state <= level_state(y_q);
                    stuck <= 1'b0;
                end
            end
        end
    end

    assign mon_state = state;

`ifdef JK_MON_HIST_EN
    // History includes the baseline sample and ignores clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist <= 8'h00;
        end else if (en) begin
            hist <= {hist[6:0], y_in};
        end
    end
`endif

endmodule

// File: tb/tb_jk_toggle_monitor.sv
module tb_jk_toggle_monitor;

    localparam int CNT_W     = 4;
    localparam int STUCK_LEN = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             clear = 1'b0;
    logic             y_in = 1'b0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] toggle_cnt;
    logic             cnt_sat;
    logic             stuck;
    logic [1:0]       mon_state;
`ifdef JK_MON_HIST_EN
    logic [7:0]       hist;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_toggle_monitor #(
        .CNT_W     (CNT_W),
        .STUCK_LEN (STUCK_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .y_in       (y_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .toggle_cnt (toggle_cnt),
        .cnt_sat    (cnt_sat),
        .stuck      (stuck),
        .mon_state  (mon_state)
`ifdef JK_MON_HIST_EN
        ,
        .hist       (hist)
`endif
    );

    // Reference model: observed level, equal-sample count since the run began,
    // toggle tally and flags, all as plain integers.
    bit       m_based;
    bit       m_level;
    int       m_run;
    int       m_cnt;
    bit       m_sat;
    bit       m_stuck;
    bit       m_rise;
    bit       m_fall;
    bit [7:0] m_hist;

    function automatic int m_state();
        if (!m_based) return 0;
        if (m_stuck)  return 3;
        return m_level ? 2 : 1;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c, input bit y);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!r) begin
            m_based = 1'b0; m_level = 1'b0; m_run = 0; m_cnt = 0;
            m_sat = 1'b0; m_stuck = 1'b0; m_hist = 8'h00;
        end else begin
            if (e) begin
                m_hist = {m_hist[6:0], y};
                if (!m_based) begin
                    m_based = 1'b1;
                    m_level = y;
                end else if (y != m_level) begin
                    m_level = y;
                    m_rise  = y;
                    m_fall  = !y;
                    m_run   = 0;
                    m_stuck = 1'b0;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (m_cnt == CNT_MAX) m_sat = 1'b1;
                end else begin
                    m_run++;
                    if (m_run == STUCK_LEN - 1) m_stuck = 1'b1;
                end
            end
            if (c) begin
                m_cnt = 0; m_sat = 1'b0; m_run = 0; m_stuck = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare every output with the model.
    task automatic cycle(input bit r, input bit e, input bit c, input bit y);
        rst = r; en = e; clear = c; y_in = y;
        @(posedge clk);
        #1;
        model_step(r, e, c, y);
        check("mdl_rise",  int'(rise_pulse), int'(m_rise));
        check("mdl_fall",  int'(fall_pulse), int'(m_fall));
        check("mdl_cnt",   int'(toggle_cnt), m_cnt);
        check("mdl_sat",   int'(cnt_sat),    int'(m_sat));
        check("mdl_stuck", int'(stuck),      int'(m_stuck));
        check("mdl_state", int'(mon_state),  m_state());
`ifdef JK_MON_HIST_EN
        check("mdl_hist",  int'(hist),       int'(m_hist));
`endif
    endtask

    task automatic expect_out(input string tag, input bit er, input bit ef, input int ecnt,
                              input bit esat, input bit estk, input int est);
        check({tag, "_rise"},  int'(rise_pulse), int'(er));
        check({tag, "_fall"},  int'(fall_pulse), int'(ef));
        check({tag, "_cnt"},   int'(toggle_cnt), ecnt);
        check({tag, "_sat"},   int'(cnt_sat),    int'(esat));
        check({tag, "_stuck"}, int'(stuck),      int'(estk));
        check({tag, "_state"}, int'(mon_state),  est);
    endtask

    typedef struct {
        bit r, e, c, y;
        bit er, ef;
        int ecnt;
        bit esat, estk;
        int est;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit c, bit y, bit er, bit ef, int ecnt,
                                bit esat, bit estk, int est);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.y = y;
        v.er = er; v.ef = ef; v.ecnt = ecnt; v.esat = esat; v.estk = estk; v.est = est;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        //            r  e  c  y   rise fall cnt sat stk st
        vecs[0]  = mk(0, 0, 0, 0,  0,   0,   0,  0,  0,  0); // reset
        vecs[1]  = mk(0, 1, 1, 1,  0,   0,   0,  0,  0,  0); // reset beats en/clear
        vecs[2]  = mk(1, 1, 0, 1,  0,   0,   0,  0,  0,  2); // baseline high
        vecs[3]  = mk(1, 0, 0, 0,  0,   0,   0,  0,  0,  2); // en=0 freezes
        vecs[4]  = mk(0, 1, 0, 0,  0,   0,   0,  0,  0,  0); // reset again
        vecs[5]  = mk(1, 1, 0, 0,  0,   0,   0,  0,  0,  1); // baseline low
        vecs[6]  = mk(1, 1, 0, 0,  0,   0,   0,  0,  0,  1); // hold
        vecs[7]  = mk(1, 1, 0, 1,  1,   0,   1,  0,  0,  2); // rise
        vecs[8]  = mk(1, 1, 0, 0,  0,   1,   2,  0,  0,  1); // fall
        vecs[9]  = mk(1, 1, 0, 1,  1,   0,   3,  0,  0,  2); // rise
        vecs[10] = mk(1, 0, 0, 0,  0,   0,   3,  0,  0,  2); // en=0, y toggles
        vecs[11] = mk(1, 0, 0, 1,  0,   0,   3,  0,  0,  2);
        vecs[12] = mk(1, 0, 0, 0,  0,   0,   3,  0,  0,  2);
        vecs[13] = mk(1, 1, 1, 0,  0,   1,   0,  0,  0,  1); // clear + toggle
        vecs[14] = mk(1, 1, 0, 0,  0,   0,   0,  0,  0,  1); // hold

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].y);
            expect_out($sformatf("vec%0d", i), vecs[i].er, vecs[i].ef, vecs[i].ecnt,
                       vecs[i].esat, vecs[i].estk, vecs[i].est);
        end

        // Stuck after STUCK_LEN equal samples, counting the baseline.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 1; i <= STUCK_LEN - 2; i++) cycle(1, 1, 0, 0);
        expect_out("pre_stuck", 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0);
        expect_out("stuck_on", 0, 0, 0, 0, 1, 3);
        cycle(1, 1, 0, 0);
        expect_out("stuck_hold", 0, 0, 0, 0, 1, 3);
        cycle(1, 1, 0, 1);
        expect_out("stuck_exit", 1, 0, 1, 0, 0, 2);
        // Clear leaves S_STUCK to the level state.
        for (int i = 1; i <= STUCK_LEN - 1; i++) cycle(1, 1, 0, 1);
        expect_out("stuck_again", 0, 0, 1, 0, 1, 3);
        cycle(1, 1, 1, 1);
        expect_out("clear_stuck", 0, 0, 0, 0, 0, 2);

        // Toggle-count saturation.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int k = 1; k <= 14; k++) cycle(1, 1, 0, 1'(k % 2));
        expect_out("cnt14", 0, 1, 14, 0, 0, 1);
        cycle(1, 1, 0, 1);
        expect_out("cnt15", 1, 0, 15, 1, 0, 2);
        cycle(1, 1, 0, 0);
        expect_out("cnt16", 0, 1, 15, 1, 0, 1);
        cycle(1, 0, 1, 0);
        expect_out("cnt_clear", 0, 0, 0, 0, 0, 1);

        // Mid-run reset with a count and a stuck flag pending.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) cycle(1, 1, 0, 1'(k % 2));
        for (int i = 1; i <= STUCK_LEN - 1; i++) cycle(1, 1, 0, 1);
        expect_out("pre_rst", 0, 0, 5, 0, 1, 3);
        cycle(0, 1, 0, 0);
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1);
        expect_out("rebase", 0, 0, 0, 0, 0, 2);

`ifdef JK_MON_HIST_EN
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        check("hist_1011", int'(hist), 8'h0B);
`endif

        // Random traffic against the model; y mostly holds so stuck runs occur.
        begin
            bit ycur = 1'b0;
            for (int n = 0; n < 4000; n++) begin
                bit r, e, c;
                r = ($urandom_range(0, 99) >= 2);
                e = ($urandom_range(0, 9) < 8);
                c = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 9) < 3) ycur = ~ycur;
                cycle(r, e, c, ycur);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
